// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: operation encodings, divider FSM states
// and small decode helpers for the M-extension divide operations.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } div_state_t;

  // funct3[0] clear marks the signed forms, funct3[1] set selects the remainder
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Plain ripple-style adder with carry in/out, used by the divider for the trial
// subtraction (caller inverts the subtrahend and drives cin=1).
module Adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: magnitudes are divided
// over N cycles, then sign fix-up and divide-by-zero overrides are applied once.
module seq_divider
  import rv_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] R
);

  localparam int CW = $clog2(N);

  div_state_t   state, state_nxt;
  logic         rem_op, sign_q, sign_r, div0;
  logic [N-1:0] dvd, dvs, rem, a_orig;
  logic [CW-1:0] cnt;

  logic         accept, is_signed, qbit, cout;
  logic [N-1:0] a_mag, b_mag, res;
  logic [N:0]   t, diff;

  assign ready  = (state == S_IDLE);
  assign busy   = (state != S_IDLE);
  assign accept = ready && start && !flush;

  assign t = {rem, dvd[N-1]};

  Adder #(.W(N + 1)) u_add (
    .a   (t),
    .b   (~{1'b0, dvs}),
    .cin (1'b1),
    .sum (diff),
    .cout(cout)
  );

  // A carry out means t >= dvs, in which case the difference always fits in N bits
  assign qbit = cout & ~diff[N];

  always_comb begin
    is_signed = op_is_signed(op);
    a_mag     = (is_signed && A[N-1]) ? -A : A;
    b_mag     = (is_signed && B[N-1]) ? -B : B;
  end

  // Final result: divide-by-zero overrides take priority over sign correction
  always_comb begin
    res = '0;
    if (rem_op) begin
      if (div0) res = a_orig;
      else      res = sign_r ? -rem : rem;
    end else begin
      if (div0) res = {N{1'b1}};
      else      res = sign_q ? -dvd : dvd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ITER;
      S_ITER:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_op <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      a_orig <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      R      <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        rem_op <= op_is_rem(op);
        sign_q <= is_signed & (A[N-1] ^ B[N-1]);
        sign_r <= is_signed & A[N-1];
        div0   <= (B == '0);
        dvd    <= a_mag;
        dvs    <= b_mag;
        rem    <= '0;
        a_orig <= A;
        cnt    <= CW'(N - 1);
      end else if (state == S_ITER && !flush) begin
        rem <= qbit ? diff[N-1:0] : t[N-1:0];
        dvd <= {dvd[N-2:0], qbit};
        cnt <= cnt - 1'b1;
      end else if (state == S_FIX && !flush) begin
        valid <= 1'b1;
        R     <= res;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider: results are scoreboarded against
// bench-side expectations, plus latency, handshake, flush and reset behaviour.
module tb_seq_divider;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] A, B, R;
  logic        ready, busy, valid;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expq[$];
  logic [31:0] lastExp = 32'h0;

  seq_divider #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .A(A), .B(B), .ready(ready), .busy(busy), .valid(valid), .R(R)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V division semantics, including the zero and overflow cases
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return sa / sb;
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
               else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request and let it be sampled by the next rising edge
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
  endtask

  // Wait (bounded) for valid, then check handshake, latency and the scoreboard head
  task automatic checkOutput(input string tag, input int lat);
    int n;
    logic rdyOk;
    logic [31:0] e;
    n = 0;
    rdyOk = 1'b1;
    while (valid !== 1'b1 && n < 60) begin
      if (ready !== 1'b0 || busy !== 1'b1) rdyOk = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
    cmp({tag, " busy"}, 32'(rdyOk), 32'd1);
    cmp({tag, " latency"}, n, lat);
    cmp({tag, " R"}, R, e);
    lastExp = e;
    @(posedge clk); #1;
    cmp({tag, " pulse"}, 32'(valid), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    applyStimulus(o, a, b);
    expq.push_back(exp);
    checkOutput(tag, 33);
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; A = '0; B = '0;
    #12;
    cmp("reset ready", 32'(ready), 32'd1);
    cmp("reset busy", 32'(busy), 32'd0);
    cmp("reset valid", 32'(valid), 32'd0);
    cmp("reset R", R, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    runOp("div -7/2", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    runOp("rem -7/2", OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    runOp("remu 7/-2", OP_REMU, 32'd7, 32'hFFFF_FFFE, 32'd7);
    runOp("div0 div", OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF);
    runOp("div0 rem", OP_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB);
    runOp("ovf div", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("ovf rem", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    runOp("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Flush part way through the iterations: nothing must come out
    applyStimulus(OP_DIVU, 32'd500, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cmp("flush iter ready", 32'(ready), 32'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (valid === 1'b1) seen++; end
    cmp("flush iter no valid", seen, 0);
    cmp("flush iter R kept", R, lastExp);
    runOp("after flush", OP_DIVU, 32'd500, 32'd3, 32'd166);

    // Flush in the fix-up cycle suppresses both valid and the R update
    applyStimulus(OP_DIVU, 32'd81, 32'd9);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cmp("flush fix valid", 32'(valid), 32'd0);
    cmp("flush fix R kept", R, lastExp);
    cmp("flush fix ready", 32'(ready), 32'd1);

    // start together with flush in IDLE is not accepted
    op = OP_DIVU; A = 32'd10; B = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    cmp("start+flush busy", 32'(busy), 32'd0);

    // start while busy is ignored
    applyStimulus(OP_DIVU, 32'd1000, 32'd10);
    expq.push_back(32'd100);
    repeat (3) begin @(posedge clk); #1; end
    op = OP_DIVU; A = 32'd9; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start while busy", 29);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (valid === 1'b1) seen++; end
    cmp("no queued op", seen, 0);

    // Asynchronous reset mid-iteration
    applyStimulus(OP_DIV, 32'd12345, 32'd67);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    cmp("async rst R", R, 32'h0);
    cmp("async rst valid", 32'(valid), 32'd0);
    cmp("async rst ready", 32'(ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("after reset", OP_REMU, 32'd12345, 32'd67, 32'd17);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = (i == 7) ? 32'd1 : $urandom >> (i * 3);
      runOp($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
